// File: rtl/mem_responder.sv
// ============================================================================
// mem_responder : handshaked multi-cycle data memory for the MEM-stage port
// Optional fault detection enabled by defining MEM_RESPONDER_ERR_EN.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module mem_responder #(
   parameter int DEPTH_WORDS = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        memreads,
   input  logic        memwrites,
   input  logic [31:0] dir,
   input  logic [31:0] datain,
   output logic [31:0] dataout,
   output logic        ready,
   output logic        stall,
   output logic        err
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            wr_q, wr_d;
   logic            fault_q, fault_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [31:0]     dataout_q, dataout_d;
   logic            commit;
   logic            mem_we;
   logic            req;
   logic            req_fault;

   logic [31:0]     mem [DEPTH_WORDS];

   assign req = memreads | memwrites;

`ifdef MEM_RESPONDER_ERR_EN
   assign req_fault = (dir[1:0] != 2'b00) | (dir[31:AW+2] != '0) | (memreads & memwrites);
`else
   logic unused_dir;
   assign unused_dir = ^{dir[31:AW+2], dir[1:0]};
   assign req_fault  = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      fault_d = fault_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               wr_d    = memwrites;
               fault_d = req_fault;
               idx_d   = dir[2 +: AW];
               wdata_d = datain;
               cnt_d   = CNT_INIT;
               state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // The _d copies are valid on the entering edge even with zero wait states.
      commit    = (state_d == S_RESP) && (state_q != S_RESP);
      mem_we    = commit & wr_d & ~fault_d;
      dataout_d = dataout_q;
      if (commit) begin
         if (fault_d) begin
            dataout_d = 32'd0;
         end else if (!wr_d) begin
            dataout_d = mem[idx_d];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= 4'd0;
         wr_q      <= 1'b0;
         fault_q   <= 1'b0;
         idx_q     <= '0;
         wdata_q   <= 32'd0;
         dataout_q <= 32'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wr_q      <= wr_d;
         fault_q   <= fault_d;
         idx_q     <= idx_d;
         wdata_q   <= wdata_d;
         dataout_q <= dataout_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && mem_we) begin
         mem[idx_d] <= wdata_d;
      end
   end

   assign dataout = dataout_q;
   assign ready   = (state_q == S_RESP);
   assign err     = (state_q == S_RESP) & fault_q;
   assign stall   = ((state_q == S_IDLE) & req) | (state_q == S_WAIT);

endmodule

`default_nettype wire

// File: doc/mem_responder.md
# mem_responder

Data-memory responder serving the MEM-stage load/store port of the pipelined datapath. It accepts one read or write request at a time from the EX/MEM-side signals (`memreads`, `memwrites`, `dir`, `datain`). It inserts a configurable number of wait states, then completes the access with a one-cycle `ready` pulse. It drives `stall` so the pipeline holds its buffers while an access is outstanding, which replaces the zero-latency combinational data memory with a multi-cycle, handshaked target.

## Interface
- `DEPTH_WORDS`, 64: number of 32-bit words stored; power of two, 4..1024.
- `WAIT_CYCLES`, 2: wait states inserted before the response; 0..15.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `memreads`  in  1  read request; held until `ready`.
- `memwrites`  in  1  write request; held until `ready`.
- `dir`  in  32  byte address.
- `datain`  in  32  store data.
- `dataout`  out  32  load data; valid when `ready`=1.
- `ready`  out  1  one-cycle completion pulse.
- `stall`  out  1  pipeline hold request.
- `err`  out  1  access fault, qualified by `ready`.

## Operation
- **Request:** `req = memreads | memwrites`. If both are set, the access is a write.
- **FSM states:** IDLE, WAIT, RESP.
- **IDLE:**
  - If `req` is high at the edge, latch the op, `dir` and `datain`.
  - Go to WAIT with `cnt = WAIT_CYCLES-1`.
  - If `WAIT_CYCLES` is 0, go directly to RESP.
- **WAIT:**
  - Decrement `cnt` each edge.
  - At `cnt == 0`, go to RESP.
  - Changes on the request inputs are ignored, because the request is already latched.
- **Entering RESP (edge):**
  - Read: `dataout <= mem[idx]`.
  - Write: `mem[idx] <= datain_latched`.
  - `dataout` keeps its previous value on a write.
- **RESP:**
  - `ready = 1` for exactly one cycle.
  - The next state is always IDLE.
  - A request present in the cycle after RESP is a new request, because the pipeline advanced on `ready`.
- **Index:** `idx = dir[2 +: log2(DEPTH_WORDS)]`.
- **Outputs:**
  - `stall = (IDLE & req) | WAIT`. `stall` is 0 in RESP, which is the cycle the pipeline advances.
  - `ready` and `err` are Moore outputs decoded from the state and the latched flags.
- **Single outstanding access:** no queueing. Back-to-back requests see an IDLE cycle between them, because RESP always returns to IDLE.
- **Memory contents:** not reset. `dataout` and the state are reset.

## Timing
- **Reset values:** state=IDLE, `cnt`=0, `dataout`=0, `ready`=0, `err`=0. `stall` follows `req` combinationally after reset.
- **Latency:** request first high in cycle 0 gives `ready`=1 in cycle `WAIT_CYCLES+1`.
  - `WAIT_CYCLES=2` gives `ready` in cycle 3.
  - `WAIT_CYCLES=0` gives `ready` in cycle 1.
- **Throughput:** one access per `WAIT_CYCLES+2` cycles with a continuous request stream.
- **Write visibility:** a write completed in cycle N is visible to a read whose request starts in cycle N+1 or later.
- **Reset mid-operation** (in WAIT or RESP at a reset edge):
  - Return to IDLE and discard the pending access.
  - A write not yet in RESP is not committed.
  - `ready` does not pulse.
- **Request dropped in WAIT:** the access still completes and `ready` still pulses.

## Configuration
- **`MEM_RESPONDER_ERR_EN` defined:**
  - A fault is `dir[1:0] != 0` or `dir >= 4*DEPTH_WORDS`.
  - A simultaneous `memreads` and `memwrites` is also a fault.
  - On a fault, `err`=1 with the `ready` pulse, no array write occurs, and `dataout` is forced to 0.
- **`MEM_RESPONDER_ERR_EN` not defined:**
  - `err` is tied to 0.
  - `dir[1:0]` is ignored and the address wraps modulo `DEPTH_WORDS`.
  - Both requests set simultaneously perform a write.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles with `memreads`=1 → `ready`=0, `dataout`=0, state IDLE. Release → `ready` in cycle 3 (`WAIT_CYCLES`=2).
- **Write then read:** write `dir`=0x10, `datain`=0xDEADBEEF → `stall`=1 in cycles 0-2, `ready` in cycle 3. Then read `dir`=0x10 → `dataout`=0xDEADBEEF with `ready` 3 cycles later.
- **Zero wait states:** `WAIT_CYCLES`=0, continuous reads of 0x0, 0x4, 0x8 → `ready` every 2nd cycle, `stall` high only in IDLE cycles.
- **Reset mid-write:** write 0x20=0x12345678, pulse `rst_n`=0 in cycle 1 → no `ready` pulse. A later read of 0x20 returns the prior value.
- **Fault, `ERR_EN` defined:** read `dir`=0x102 → `ready`=1, `err`=1, `dataout`=0. Write `dir`=0x100 (DEPTH 64) → `err`=1 and word 0 is unchanged.
- **Wrap, `ERR_EN` undefined:** write `dir`=0x104=0xA5A5A5A5, then read `dir`=0x4 → `dataout`=0xA5A5A5A5, `err`=0.
